// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: operation codes,
// FSM states and small opcode decode helpers.
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } mdState_t;

    function automatic logic isDivide(input mdOp_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

    function automatic logic isSignedOp(input mdOp_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift the {rem, quo} pair left by one and
// subtract the divisor from the partial remainder when it fits.
module muldiv_sequencer_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    // The shifted remainder needs one extra bit so large unsigned divisors compare correctly.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {remIn, quoIn[WIDTH-1]};
    assign diff  = trial - {1'b0, divisor};

    always_comb begin
        if (!diff[WIDTH]) begin
            remOut = diff[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = trial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer for the EX stage: one-cycle registered multiply,
// WIDTH-iteration restoring divide, EX stall request and a done pulse with hi/lo.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdState_t           state, stateNext;
    mdOp_t              opIn;
    logic [CNT_W-1:0]   counter;
    logic               signedReg, negQuo, negRem;
    logic [WIDTH-1:0]   remReg, quoReg, divisor;
    logic [WIDTH-1:0]   remStep, quoStep;
    logic [WIDTH-1:0]   srcaMag, srcbMag;
    logic [2*WIDTH-1:0] mulA, mulB, product;
    logic               accept, lastStep;

    assign opIn     = mdOp_t'(op);
    assign accept   = (state == S_IDLE) && start && !cancel;
    assign lastStep = (counter == CNT_W'(WIDTH - 1));
    assign srcaMag  = (isSignedOp(opIn) && srca[WIDTH-1]) ? -srca : srca;
    assign srcbMag  = (isSignedOp(opIn) && srcb[WIDTH-1]) ? -srcb : srcb;

    // Multiply operands live in quoReg/divisor; sign-extending to 2*WIDTH makes the
    // low half of an ordinary product the correct signed or unsigned result.
    assign mulA    = {{WIDTH{signedReg & quoReg[WIDTH-1]}}, quoReg};
    assign mulB    = {{WIDTH{signedReg & divisor[WIDTH-1]}}, divisor};
    assign product = mulA * mulB;

    muldiv_sequencer_div_step #(.WIDTH(WIDTH)) divStep (
        .remIn  (remReg),
        .quoIn  (quoReg),
        .divisor(divisor),
        .remOut (remStep),
        .quoOut (quoStep)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stateNext = state;
        if (cancel) begin
            stateNext = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    if (!isDivide(opIn))  stateNext = S_MUL;
                    else if (srcb == '0)  stateNext = S_DONE;
                    else                  stateNext = S_DIV;
                end
                S_MUL:  stateNext = S_DONE;
                S_DIV:  if (lastStep) stateNext = S_DONE;
                S_DONE: stateNext = S_IDLE;
                default: stateNext = S_IDLE;
            endcase
        end
    end

    assign busy  = (state == S_MUL) || (state == S_DIV);
    assign done  = (state == S_DONE);
    // Gated by rst so the hazard unit sees no stall while reset is held.
    assign stall = rst && (accept || busy);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            counter   <= '0;
            signedReg <= 1'b0;
            negQuo    <= 1'b0;
            negRem    <= 1'b0;
            remReg    <= '0;
            quoReg    <= '0;
            divisor   <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= stateNext;
            if (!cancel) begin
                unique case (state)
                    S_IDLE: if (start) begin
                        signedReg <= isSignedOp(opIn);
                        negQuo    <= isSignedOp(opIn) && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        negRem    <= isSignedOp(opIn) && srca[WIDTH-1];
                        counter   <= '0;
                        remReg    <= '0;
                        if (isDivide(opIn)) begin
                            quoReg  <= srcaMag;
                            divisor <= srcbMag;
                            if (srcb == '0) begin
                                hi <= srca;
                                lo <= '1;
                            end
                        end else begin
                            quoReg  <= srca;
                            divisor <= srcb;
                        end
                    end
                    S_MUL: begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end
                    S_DIV: begin
                        remReg  <= remStep;
                        quoReg  <= quoStep;
                        counter <= counter + CNT_W'(1);
                        if (lastStep) begin
                            hi <= negRem ? -remStep : remStep;
                            lo <= negQuo ? -quoStep : quoStep;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic/latency model compared every
// cycle, plus directed vectors with hand-computed hi/lo and latency literals.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srca = '0, srcb = '0;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0, failures = 0;
    bit chkEn = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .cancel(cancel), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic.
    task automatic modelResult(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] rHi, output logic [W-1:0] rLo);
        int sa, sb;
        longint sp, sq, sr;
        longint unsigned up;
        sa = a;
        sb = b;
        case (o)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                rHi = sp[63:32]; rLo = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                rHi = up[63:32]; rLo = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    rHi = a; rLo = '1;
                end else begin
                    sq = longint'(sa) / longint'(sb);
                    sr = longint'(sa) % longint'(sb);
                    rHi = sr[31:0]; rLo = sq[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    rHi = a; rLo = '1;
                end else begin
                    rHi = a % b; rLo = a / b;
                end
            end
        endcase
    endtask

    // Latency model: cycles remaining until the done cycle, and the result to publish then.
    int           mLeft = 0;
    bit           mInDone = 0;
    logic [W-1:0] mHi = '0, mLo = '0, pendHi = '0, pendLo = '0;

    always @(posedge clk or negedge rst) begin
        bit wasDone;
        if (!rst) begin
            mLeft = 0; mInDone = 0; mHi = '0; mLo = '0;
        end else begin
            wasDone = mInDone;
            mInDone = 0;
            if (cancel) begin
                mLeft = 0;
            end else if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mInDone = 1; mHi = pendHi; mLo = pendLo;
                end
            end else if (!wasDone && start) begin
                modelResult(op, srca, srcb, pendHi, pendLo);
                mLeft = (op[1] == 1'b0) ? 1 : ((srcb == '0) ? 0 : W);
                if (mLeft == 0) begin
                    mInDone = 1; mHi = pendHi; mLo = pendLo;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit expBusy, expStall;
        if (chkEn) begin
            expBusy  = rst && (mLeft > 0);
            expStall = rst && (expBusy || (mLeft == 0 && !mInDone && start && !cancel));
            check("stall", stall, expStall);
            check("busy", busy, expBusy);
            check("done", done, rst && mInDone);
            check("hi", hi, mHi);
            check("lo", lo, mLo);
        end
    end

    // Called just after a rising edge; holds start through DONE like a stalled EX stage.
    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int expLat,
                         input logic [W-1:0] eHi, input logic [W-1:0] eLo);
        int k, stallCnt;
        bit seen;
        k = -1; stallCnt = 0; seen = 0;
        start = 1'b1; op = o; srca = a; srcb = b;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (stall) stallCnt++;
            if (k == 1) begin
                srca = ~a; srcb = ~b;
            end
            if (done) seen = 1;
        end
        check({name, ".latency"}, k, expLat);
        check({name, ".stallCycles"}, stallCnt, expLat);
        check({name, ".hi"}, hi, eHi);
        check({name, ".lo"}, lo, eLo);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic noDone(input string name, input int cycles);
        int n;
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
        check(name, n, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        rst = 1'b1;
        chkEn = 1;

        runOp("mult_neg3x5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,        2,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runOp("divu_100_7",    OP_DIVU,  32'd100,       32'd7,        33, 32'd2,         32'd14);
        runOp("multu_max_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,        2,  32'd1,         32'hFFFF_FFFE);
        runOp("div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,        32'h8000_0000);
        runOp("divu_9_0",      OP_DIVU,  32'd9,         32'd0,        1,  32'd9,         32'hFFFF_FFFF);
        runOp("divu_bigdiv",   OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0000, 33, 32'h7FFF_FFFF, 32'd1);
        runOp("div_7_neg2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD);
        runOp("mult_minsq",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'd0);
        runOp("div_neg8_0",    OP_DIV,   32'hFFFF_FFF8, 32'd0,        1,  32'hFFFF_FFF8, 32'hFFFF_FFFF);

        // Cancel during the 10th DIV cycle: no done, hi/lo keep the previous result.
        start = 1'b1; op = OP_DIV; srca = 32'hFFFF_FC18; srcb = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel.busy", busy, 0);
        check("cancel.done", done, 0);
        check("cancel.hi", hi, 32'hFFFF_FFF8);
        check("cancel.lo", lo, 32'hFFFF_FFFF);
        runOp("mult_after_cancel", OP_MULT, 32'd7, 32'hFFFF_FFFA, 2, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        noDone("cancel.noSpuriousDone", 5);

        // Cancel and start together in IDLE: nothing starts.
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1; op = OP_MULT; srca = 32'd3; srcb = 32'd3;
        #2;
        check("cancelStart.stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancelStart.busy", busy, 0);
        noDone("cancelStart.noDone", 4);

        // Reset in DIV iteration 20 with start still high.
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIVU; srca = 32'd100000; srcb = 32'd13;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midReset.busy", busy, 0);
        check("midReset.done", done, 0);
        check("midReset.stall", stall, 0);
        check("midReset.hi", hi, 0);
        check("midReset.lo", lo, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        noDone("postReset.idle", 3);
        @(posedge clk); #1;
        runOp("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        noDone("postReset.singleDone", 40);

        chkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
